xeng_corr_apply: RTL and testbench
==================================

XENG_CORR_APPLY -- requirements
Module: xeng_corr_apply

Interface
REQ-001 SHALL have parameter N_ANTS, default 32, meaning number of dual-pol antennas; N_TAPS = N_ANTS/2+1.
REQ-002 SHALL have parameter ACC_WIDTH, default 24, meaning signed width of each raw X-engine accumulator word.
REQ-003 SHALL have parameter CORR_WIDTH, default 16, meaning signed width of each correction word (P_FACTOR_BITS+SERIAL_ACC_LEN_BITS+BITWIDTH+3).
REQ-004 SHALL have parameter FIFO_DEPTH_BITS, default 2, meaning log2 depth of the correction FIFO.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sync  input  1  window-start pulse, aligned with first corr_vld of a window.
REQ-008 corr_vld  input  1  correction set present this cycle.
REQ-009 corr_re  input  4*CORR_WIDTH  {xx,xy,yx,yy} real corrections, signed.
REQ-010 corr_im  input  4*CORR_WIDTH  {xx,xy,yx,yy} imag corrections, signed.
REQ-011 corr_last_triangle  input  1  tag for the correction set.
REQ-012 corr_buf_sel  input  1  tag for the correction set.
REQ-013 din_vld  input  1  raw baseline word present.
REQ-014 din_re  input  4*ACC_WIDTH  raw real accumulators {xx,xy,yx,yy}, signed.
REQ-015 din_im  input  4*ACC_WIDTH  raw imag accumulators, same order.
REQ-016 dout_vld  output  1  corrected word valid.
REQ-017 dout_re, dout_im  output  4*(ACC_WIDTH+1) each  corrected words, signed.
REQ-018 dout_bl  output  log2(N_TAPS)+1  baseline index within window.
REQ-019 dout_last_triangle, dout_buf_sel  output  1 each  tags carried from the consumed correction set.
REQ-020 err_underflow, err_overflow  output  1 each  sticky error flags.

Function
REQ-021 Each corr_vld cycle SHALL push {corr_re,corr_im,tags} into a 2^FIFO_DEPTH_BITS-entry FIFO.
REQ-022 Each din_vld cycle in state RUN SHALL pop one FIFO entry and pair it with din.
REQ-023 Per lane: dout = sign_extend(din, ACC_WIDTH+1) - sign_extend(corr, ACC_WIDTH+1), no saturation; CORR_WIDTH <= ACC_WIDTH required.
REQ-024 Latency SHALL be 2 cycles din_vld -> dout_vld (FIFO read register, subtract register); tags and dout_bl delayed identically.
REQ-025 FSM states IDLE, RUN, ERR; IDLE->RUN on sync; RUN->ERR on underflow or overflow; ERR->RUN only on next sync (FIFO flushed that cycle, flags remain set).
REQ-026 In IDLE and ERR, din_vld SHALL be ignored (dout_vld stays 0); corr_vld pushes still accepted in IDLE only after sync.
REQ-027 Underflow: din_vld in RUN with FIFO empty and no same-cycle push -> err_underflow=1, no dout_vld.
REQ-028 Simultaneous push and pop on an empty FIFO SHALL bypass: incoming correction used directly, no error.
REQ-029 Overflow: push with FIFO full and no same-cycle pop -> err_overflow=1, entry dropped; push+pop when full is legal.
REQ-030 dout_bl SHALL count 0..N_TAPS-1 per output, wrap to 0 after N_TAPS-1, and clear to 0 on sync.
REQ-031 sync coincident with din_vld SHALL flush FIFO first, then apply REQ-028 to the same-cycle push/pop.

Reset
REQ-032 While rst_n=0: state IDLE, FIFO empty, all outputs 0, err flags 0, dout_bl 0.
REQ-033 Reset assertion mid-window SHALL discard all in-flight pipeline data with no dout_vld emitted afterwards until a new sync.

Structure
REQ-034 State encoding and N_TAPS/bit-width helper functions SHALL live in shared package xeng_pkg.
REQ-035 The FIFO SHALL be a sub-module corr_fifo (sync FIFO, full/empty, async active-low reset).

Verification
REQ-036 N_ANTS=4: sync, 3 corr sets re_xx=5,-3,0, then 3 din re_xx=100 -> dout_re_xx=95,103,100, dout_bl 0,1,2, 2-cycle latency.
REQ-037 din_vld with empty FIFO in RUN -> err_underflow=1, state ERR, dout_vld=0 until next sync.
REQ-038 5 pushes without pops (depth 4) -> err_overflow=1 on 5th push, 5th entry dropped.
REQ-039 Same-cycle corr_vld and din_vld on empty FIFO with corr_im_yy=-7, din_im_yy=-8 -> dout_im_yy=-1, no error.
REQ-040 din_re_xx = -(2^(ACC_WIDTH-1)), corr_re_xx = 1 -> dout_re_xx = -(2^(ACC_WIDTH-1))-1 exact in ACC_WIDTH+1 bits.
REQ-041 rst_n pulled low one cycle after a din_vld -> no dout_vld, all outputs 0 immediately (async).

Source files
------------

// File: rtl/xeng_pkg.sv
// Shared types and elaboration helpers for the X-engine correction path.
package xeng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Polarisation products per baseline word: {xx,xy,yx,yy}, xx in the top lane.
    localparam int N_LANES = 4;

    // Baselines per window for an N_ANTS dual-pol array.
    function automatic int n_taps(input int n_ants);
        return n_ants / 2 + 1;
    endfunction

    // Width of the baseline counter, with one spare bit of headroom.
    function automatic int bl_width(input int n_ants);
        return $clog2(n_ants / 2 + 1) + 1;
    endfunction

endpackage

// File: rtl/xeng_corr_apply_if.sv
// Correction / raw-data / corrected-output bundle for xeng_corr_apply.
interface xeng_corr_apply_if #(
    parameter int N_ANTS     = 32,
    parameter int ACC_WIDTH  = 24,
    parameter int CORR_WIDTH = 16
) ();
    localparam int BL_W = xeng_pkg::bl_width(N_ANTS);

    logic                      sync;
    logic                      corr_vld;
    logic [4*CORR_WIDTH-1:0]   corr_re;
    logic [4*CORR_WIDTH-1:0]   corr_im;
    logic                      corr_last_triangle;
    logic                      corr_buf_sel;
    logic                      din_vld;
    logic [4*ACC_WIDTH-1:0]    din_re;
    logic [4*ACC_WIDTH-1:0]    din_im;
    logic                      dout_vld;
    logic [4*(ACC_WIDTH+1)-1:0] dout_re;
    logic [4*(ACC_WIDTH+1)-1:0] dout_im;
    logic [BL_W-1:0]           dout_bl;
    logic                      dout_last_triangle;
    logic                      dout_buf_sel;
    logic                      err_underflow;
    logic                      err_overflow;

    modport master (
        output sync, corr_vld, corr_re, corr_im, corr_last_triangle, corr_buf_sel,
               din_vld, din_re, din_im,
        input  dout_vld, dout_re, dout_im, dout_bl, dout_last_triangle, dout_buf_sel,
               err_underflow, err_overflow
    );

    modport slave (
        input  sync, corr_vld, corr_re, corr_im, corr_last_triangle, corr_buf_sel,
               din_vld, din_re, din_im,
        output dout_vld, dout_re, dout_im, dout_bl, dout_last_triangle, dout_buf_sel,
               err_underflow, err_overflow
    );
endinterface

// File: rtl/corr_fifo.sv
// Small synchronous FIFO holding pending correction sets. A flush empties the
// queue and a same-cycle push then lands in a fresh, empty FIFO.
module corr_fifo #(
    parameter int WIDTH      = 130,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CNT_W = DEPTH_BITS + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_BITS-1:0] wr_base, rd_base;
    logic [CNT_W-1:0]      cnt_base;

    assign rd_data = mem[rd_ptr_q];
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);

    // Pointer/count update; flush restarts from zero before applying push/pop.
    always_comb begin
        wr_base  = flush ? '0 : wr_ptr_q;
        rd_base  = flush ? '0 : rd_ptr_q;
        cnt_base = flush ? '0 : cnt_q;
        wr_ptr_d = wr_base + {{(DEPTH_BITS-1){1'b0}}, push};
        rd_ptr_d = rd_base + {{(DEPTH_BITS-1){1'b0}}, pop};
        cnt_d    = cnt_base + {{DEPTH_BITS{1'b0}}, push} - {{DEPTH_BITS{1'b0}}, pop};
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_base] <= wr_data;
    end

endmodule

// File: rtl/xeng_corr_apply.sv
// Subtracts queued correction sets from raw X-engine accumulator words.
// Two-stage pipeline: pick correction (FIFO head or bypass), then subtract.
module xeng_corr_apply
    import xeng_pkg::*;
#(
    parameter int N_ANTS          = 32,
    parameter int ACC_WIDTH       = 24,
    parameter int CORR_WIDTH      = 16,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    xeng_corr_apply_if.slave bus
);
    localparam int N_TAPS = n_taps(N_ANTS);
    localparam int BL_W   = bl_width(N_ANTS);
    localparam int EW     = ACC_WIDTH + 1;
    localparam int ENT_W  = 2 * N_LANES * CORR_WIDTH + 2;

    typedef logic [N_LANES-1:0][CORR_WIDTH-1:0] corr_vec_t;
    typedef logic [N_LANES-1:0][ACC_WIDTH-1:0]  acc_vec_t;
    typedef logic [N_LANES-1:0][EW-1:0]         out_vec_t;

    // Control state
    state_e          state_q, state_d;
    logic [BL_W-1:0] bl_q, bl_d, bl_base;
    logic            err_u_q, err_u_d, err_o_q, err_o_d;

    // Stage 1: selected correction plus the raw word it pairs with
    logic            s1_vld_q, s1_vld_d;
    acc_vec_t        s1_re_q, s1_re_d, s1_im_q, s1_im_d;
    corr_vec_t       s1_cre_q, s1_cre_d, s1_cim_q, s1_cim_d;
    logic            s1_lt_q, s1_lt_d, s1_bs_q, s1_bs_d;
    logic [BL_W-1:0] s1_bl_q, s1_bl_d;

    // Stage 2: corrected output
    logic            dout_vld_q, dout_vld_d;
    out_vec_t        dout_re_q, dout_re_d, dout_im_q, dout_im_d;
    logic [BL_W-1:0] dout_bl_q, dout_bl_d;
    logic            dout_lt_q, dout_lt_d, dout_bs_q, dout_bs_d;

    // FIFO
    logic [ENT_W-1:0] fifo_wr_data, fifo_rd_data;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    corr_vec_t        head_re, head_im, in_re, in_im;
    logic             head_lt, head_bs;

    // Handshake decode
    logic active, eff_empty, eff_full, want_push, want_pop;
    logic bypass, underflow, overflow, take;

    assign fifo_wr_data = {bus.corr_re, bus.corr_im, bus.corr_last_triangle, bus.corr_buf_sel};
    assign {head_re, head_im, head_lt, head_bs} = fifo_rd_data;
    assign in_re = bus.corr_re;
    assign in_im = bus.corr_im;

    corr_fifo #(
        .WIDTH      (ENT_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (bus.sync),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Push/pop arbitration; sync counts as RUN with an already-flushed FIFO.
    always_comb begin
        active    = bus.sync || (state_q == ST_RUN);
        eff_empty = bus.sync || fifo_empty;
        eff_full  = !bus.sync && fifo_full;
        want_pop  = active && bus.din_vld;
        want_push = active && bus.corr_vld;
        bypass    = want_pop && want_push && eff_empty;
        underflow = want_pop && eff_empty && !want_push;
        overflow  = want_push && eff_full && !want_pop;
        fifo_push = want_push && !bypass && !overflow;
        fifo_pop  = want_pop && !eff_empty;
        take      = bypass || fifo_pop;
    end

    // FSM next state, sticky error flags, baseline counter.
    always_comb begin
        state_d = state_q;
        err_u_d = err_u_q || underflow;
        err_o_d = err_o_q || overflow;
        if (active) state_d = (underflow || overflow) ? ST_ERR : ST_RUN;
        bl_base = bus.sync ? '0 : bl_q;
        bl_d    = bl_base;
        if (take) bl_d = (bl_base == BL_W'(N_TAPS - 1)) ? '0 : bl_base + 1'b1;
    end

    // Stage 1 capture: correction from the FIFO head, or straight from the bus on bypass.
    always_comb begin
        s1_vld_d = take;
        s1_re_d  = s1_re_q;
        s1_im_d  = s1_im_q;
        s1_cre_d = s1_cre_q;
        s1_cim_d = s1_cim_q;
        s1_lt_d  = s1_lt_q;
        s1_bs_d  = s1_bs_q;
        s1_bl_d  = s1_bl_q;
        if (take) begin
            s1_re_d  = bus.din_re;
            s1_im_d  = bus.din_im;
            s1_cre_d = bypass ? in_re : head_re;
            s1_cim_d = bypass ? in_im : head_im;
            s1_lt_d  = bypass ? bus.corr_last_triangle : head_lt;
            s1_bs_d  = bypass ? bus.corr_buf_sel : head_bs;
            s1_bl_d  = bl_base;
        end
    end

    // Per-lane widen-and-subtract; the extra bit makes the result exact.
    out_vec_t diff_re, diff_im;
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign diff_re[g] = {s1_re_q[g][ACC_WIDTH-1], s1_re_q[g]}
                          - {{(EW-CORR_WIDTH){s1_cre_q[g][CORR_WIDTH-1]}}, s1_cre_q[g]};
        assign diff_im[g] = {s1_im_q[g][ACC_WIDTH-1], s1_im_q[g]}
                          - {{(EW-CORR_WIDTH){s1_cim_q[g][CORR_WIDTH-1]}}, s1_cim_q[g]};
    end

    // Stage 2 capture; output data holds between valid words.
    always_comb begin
        dout_vld_d = s1_vld_q;
        dout_re_d  = dout_re_q;
        dout_im_d  = dout_im_q;
        dout_bl_d  = dout_bl_q;
        dout_lt_d  = dout_lt_q;
        dout_bs_d  = dout_bs_q;
        if (s1_vld_q) begin
            dout_re_d = diff_re;
            dout_im_d = diff_im;
            dout_bl_d = s1_bl_q;
            dout_lt_d = s1_lt_q;
            dout_bs_d = s1_bs_q;
        end
    end

    // All state; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bl_q       <= '0;
            err_u_q    <= 1'b0;
            err_o_q    <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_cre_q   <= '0;
            s1_cim_q   <= '0;
            s1_lt_q    <= 1'b0;
            s1_bs_q    <= 1'b0;
            s1_bl_q    <= '0;
            dout_vld_q <= 1'b0;
            dout_re_q  <= '0;
            dout_im_q  <= '0;
            dout_bl_q  <= '0;
            dout_lt_q  <= 1'b0;
            dout_bs_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bl_q       <= bl_d;
            err_u_q    <= err_u_d;
            err_o_q    <= err_o_d;
            s1_vld_q   <= s1_vld_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s1_cre_q   <= s1_cre_d;
            s1_cim_q   <= s1_cim_d;
            s1_lt_q    <= s1_lt_d;
            s1_bs_q    <= s1_bs_d;
            s1_bl_q    <= s1_bl_d;
            dout_vld_q <= dout_vld_d;
            dout_re_q  <= dout_re_d;
            dout_im_q  <= dout_im_d;
            dout_bl_q  <= dout_bl_d;
            dout_lt_q  <= dout_lt_d;
            dout_bs_q  <= dout_bs_d;
        end
    end

    assign bus.dout_vld           = dout_vld_q;
    assign bus.dout_re            = dout_re_q;
    assign bus.dout_im            = dout_im_q;
    assign bus.dout_bl            = dout_bl_q;
    assign bus.dout_last_triangle = dout_lt_q;
    assign bus.dout_buf_sel       = dout_bs_q;
    assign bus.err_underflow      = err_u_q;
    assign bus.err_overflow       = err_o_q;

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Randomised + directed bench for xeng_corr_apply against a queue-based model.
module tb_xeng_corr_apply;
    localparam int N_ANTS = 4;
    localparam int AW     = 24;
    localparam int CW     = 16;
    localparam int FDB    = 2;
    localparam int N_TAPS = N_ANTS / 2 + 1;
    localparam int EW     = AW + 1;
    localparam int DEPTH  = 1 << FDB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    xeng_corr_apply_if #(.N_ANTS(N_ANTS), .ACC_WIDTH(AW), .CORR_WIDTH(CW)) bus ();

    xeng_corr_apply #(
        .N_ANTS(N_ANTS), .ACC_WIDTH(AW), .CORR_WIDTH(CW), .FIFO_DEPTH_BITS(FDB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4*CW-1:0] re;
        logic [4*CW-1:0] im;
        logic            lt;
        logic            bs;
    } cset_t;

    typedef struct packed {
        logic            vld;
        logic [4*EW-1:0] re;
        logic [4*EW-1:0] im;
        logic [7:0]      bl;
        logic            lt;
        logic            bs;
    } exp_t;

    cset_t mq[$];
    bit    m_run;
    int    m_bl;
    bit    m_eu, m_eo;
    exp_t  m_prev, m_cur;
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-lane exact difference of signed raw word and signed correction.
    function automatic logic [4*EW-1:0] sub4(input logic [4*AW-1:0] d, input logic [4*CW-1:0] c);
        logic [4*EW-1:0] r;
        longint dv, cv;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            dv = longint'($signed(d[i*AW +: AW]));
            cv = longint'($signed(c[i*CW +: CW]));
            r[i*EW +: EW] = EW'(dv - cv);
        end
        return r;
    endfunction

    // Behaviour for one clock of the current bus inputs.
    task automatic model_step();
        cset_t c, used;
        bit push, pop;
        m_cur = '0;
        if (bus.sync || m_run) begin
            if (bus.sync) begin
                mq.delete();
                m_bl  = 0;
                m_run = 1;
            end
            c    = {bus.corr_re, bus.corr_im, bus.corr_last_triangle, bus.corr_buf_sel};
            push = bus.corr_vld;
            pop  = bus.din_vld;
            if (pop) begin
                if (mq.size() == 0 && !push) begin
                    m_eu  = 1;
                    m_run = 0;
                end else begin
                    if (mq.size() == 0) begin
                        used = c;
                        push = 0;
                    end else begin
                        used = mq.pop_front();
                    end
                    m_cur.vld = 1'b1;
                    m_cur.re  = sub4(bus.din_re, used.re);
                    m_cur.im  = sub4(bus.din_im, used.im);
                    m_cur.bl  = 8'(m_bl);
                    m_cur.lt  = used.lt;
                    m_cur.bs  = used.bs;
                    m_bl = (m_bl + 1) % N_TAPS;
                end
            end
            if (push) begin
                if (mq.size() == DEPTH) begin
                    m_eo  = 1;
                    m_run = 0;
                end else begin
                    mq.push_back(c);
                end
            end
        end
    endtask

    task automatic check_out();
        chk("vld", 128'(bus.dout_vld), 128'(m_prev.vld));
        if (m_prev.vld) begin
            chk("re", 128'(bus.dout_re), 128'(m_prev.re));
            chk("im", 128'(bus.dout_im), 128'(m_prev.im));
            chk("bl", 128'(bus.dout_bl), 128'(m_prev.bl));
            chk("lt", 128'(bus.dout_last_triangle), 128'(m_prev.lt));
            chk("bs", 128'(bus.dout_buf_sel), 128'(m_prev.bs));
        end
        chk("err_u", 128'(bus.err_underflow), 128'(m_eu));
        chk("err_o", 128'(bus.err_overflow), 128'(m_eo));
        m_prev = m_cur;
    endtask

    task automatic step(input bit s, input bit cv, input bit dv);
        bus.sync     = s;
        bus.corr_vld = cv;
        bus.din_vld  = dv;
        model_step();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic rnd();
        bus.corr_re            = {$urandom(), $urandom()};
        bus.corr_im            = {$urandom(), $urandom()};
        bus.corr_last_triangle = 1'($urandom());
        bus.corr_buf_sel       = 1'($urandom());
        bus.din_re             = {$urandom(), $urandom(), $urandom()};
        bus.din_im             = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.sync     = 1'b0;
        bus.corr_vld = 1'b0;
        bus.din_vld  = 1'b0;
        #1;
        chk("rst_vld", 128'(bus.dout_vld), 128'(0));
        chk("rst_re", 128'(bus.dout_re), 128'(0));
        chk("rst_im", 128'(bus.dout_im), 128'(0));
        chk("rst_bl", 128'(bus.dout_bl), 128'(0));
        chk("rst_lt", 128'(bus.dout_last_triangle), 128'(0));
        chk("rst_bs", 128'(bus.dout_buf_sel), 128'(0));
        chk("rst_eu", 128'(bus.err_underflow), 128'(0));
        chk("rst_eo", 128'(bus.err_overflow), 128'(0));
        mq.delete();
        m_run = 0; m_bl = 0; m_eu = 0; m_eo = 0;
        m_prev = '0; m_cur = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [EW-1:0] e40;
        longint v40;
        bus.sync = 0; bus.corr_vld = 0; bus.din_vld = 0;
        bus.corr_re = '0; bus.corr_im = '0; bus.din_re = '0; bus.din_im = '0;
        bus.corr_last_triangle = 0; bus.corr_buf_sel = 0;

        // Basic window: three corrections, three raw words.
        do_reset();
        rnd(); bus.corr_re[3*CW +: CW] = CW'(5);  step(1, 1, 0);
        rnd(); bus.corr_re[3*CW +: CW] = CW'(-3); step(0, 1, 0);
        rnd(); bus.corr_re[3*CW +: CW] = CW'(0);  step(0, 1, 0);
        rnd(); bus.din_re[3*AW +: AW] = AW'(100); step(0, 0, 1);
        chk("t36_lat", 128'(bus.dout_vld), 128'(0));
        rnd(); bus.din_re[3*AW +: AW] = AW'(100); step(0, 0, 1);
        chk("t36_xx0", 128'(bus.dout_re[3*EW +: EW]), 128'(95));
        chk("t36_bl0", 128'(bus.dout_bl), 128'(0));
        rnd(); bus.din_re[3*AW +: AW] = AW'(100); step(0, 0, 1);
        chk("t36_xx1", 128'(bus.dout_re[3*EW +: EW]), 128'(103));
        chk("t36_bl1", 128'(bus.dout_bl), 128'(1));
        step(0, 0, 0);
        chk("t36_xx2", 128'(bus.dout_re[3*EW +: EW]), 128'(100));
        chk("t36_bl2", 128'(bus.dout_bl), 128'(2));
        step(0, 0, 0);

        // Underflow, ERR holds until the next sync.
        do_reset();
        rnd(); step(1, 0, 0);
        rnd(); step(0, 0, 1);
        chk("t37_eu", 128'(bus.err_underflow), 128'(1));
        repeat (3) begin rnd(); step(0, 1, 1); end
        chk("t37_quiet", 128'(bus.dout_vld), 128'(0));
        rnd(); step(1, 1, 0);
        rnd(); step(0, 0, 1);
        step(0, 0, 0);
        chk("t37_resume", 128'(bus.dout_vld), 128'(1));
        chk("t37_sticky", 128'(bus.err_underflow), 128'(1));

        // Overflow on the fifth unpopped push.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rnd(); step(i == 0, 1, 0);
            if (i == 3) chk("t38_no_eo", 128'(bus.err_overflow), 128'(0));
        end
        chk("t38_eo", 128'(bus.err_overflow), 128'(1));

        // Same-cycle push/pop on empty FIFO bypasses.
        do_reset();
        rnd(); step(1, 0, 0);
        rnd(); bus.corr_im[0 +: CW] = CW'(-7); bus.din_im[0 +: AW] = AW'(-8); step(0, 1, 1);
        step(0, 0, 0);
        chk("t39_yy", 128'(bus.dout_im[0 +: EW]), 128'({EW{1'b1}}));
        chk("t39_eu", 128'(bus.err_underflow), 128'(0));
        // sync with stale entries: flush, then bypass the same-cycle pair
        rnd(); step(0, 1, 0);
        rnd(); step(1, 1, 1);
        step(0, 0, 0);

        // Most-negative raw word minus one.
        do_reset();
        rnd(); bus.corr_re[3*CW +: CW] = CW'(1); step(1, 1, 0);
        rnd(); bus.din_re[3*AW +: AW] = {1'b1, {(AW-1){1'b0}}}; step(0, 0, 1);
        step(0, 0, 0);
        v40 = -(longint'(1) <<< (AW - 1)) - 1;
        e40 = EW'(v40);
        chk("t40_xx", 128'(bus.dout_re[3*EW +: EW]), 128'(e40));

        // Reset with data in both pipeline stages.
        do_reset();
        rnd(); step(1, 1, 0);
        rnd(); step(0, 1, 1);
        rnd(); step(0, 0, 1);
        chk("t41_pre", 128'(bus.dout_vld), 128'(1));
        do_reset();
        repeat (4) step(0, 0, 0);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rnd();
            step($urandom_range(0, 15) == 0, 1'($urandom()), $urandom_range(0, 99) < 45);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
